mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/execute) arbiter in front of a single memory unit.
// One command in flight at a time; round-robin on simultaneous requests.
module mem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        f_req,
  input  logic [31:0] f_address,
  input  logic [31:0] f_offset,
  input  logic        x_req,
  input  logic [1:0]  x_mode,
  input  logic [31:0] x_address,
  input  logic [31:0] x_offset,
  input  logic [31:0] x_data,
  output logic [1:0]  mem_mode,
  output logic [31:0] mem_address,
  output logic [31:0] mem_offset,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_data_out,
  output logic        f_ack,
  output logic        x_ack,
  output logic [31:0] rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t     state;
  logic [2:0] wait_cnt;
  logic       last_grant;   // 1 = execute was granted last
  logic       gnt_x;        // port owning the in-flight transaction
  logic       grant_x;

  // Execute wins when it is alone, or when both request and fetch had the last turn.
  assign grant_x = x_req & (~f_req | ~last_grant);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state       <= S_IDLE;
      wait_cnt    <= 3'd0;
      last_grant  <= 1'b1;
      gnt_x       <= 1'b0;
      mem_mode    <= 2'b00;
      mem_address <= 32'h0;
      mem_offset  <= 32'h0;
      mem_data    <= 32'h0;
      f_ack       <= 1'b0;
      x_ack       <= 1'b0;
      rdata       <= 32'h0;
      busy        <= 1'b0;
    end else begin
      f_ack <= 1'b0;
      x_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (f_req || x_req) begin
            gnt_x       <= grant_x;
            mem_mode    <= grant_x ? x_mode    : 2'b00;
            mem_address <= grant_x ? x_address : f_address;
            mem_offset  <= grant_x ? x_offset  : f_offset;
            mem_data    <= grant_x ? x_data    : 32'h0;
            busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Command fields stay on the bus; only the mode strobe is dropped.
          mem_mode <= 2'b00;
          wait_cnt <= LAT_M1;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_RESP: begin
          rdata      <= mem_data_out;
          f_ack      <= ~gnt_x;
          x_ack      <= gnt_x;
          last_grant <= gnt_x;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 (dut_a)
// and one at MEM_LAT=3 (dut_b) sharing the same stimulus.
module tb_mem_port_arbiter;

  logic        clk;
  logic        init_n;
  logic        f_req;
  logic [31:0] f_address;
  logic [31:0] f_offset;
  logic        x_req;
  logic [1:0]  x_mode;
  logic [31:0] x_address;
  logic [31:0] x_offset;
  logic [31:0] x_data;
  logic [31:0] mem_data_out;

  logic [1:0]  a_mem_mode;
  logic [31:0] a_mem_address, a_mem_offset, a_mem_data, a_rdata;
  logic        a_f_ack, a_x_ack, a_busy;

  logic [1:0]  b_mem_mode;
  logic [31:0] b_mem_address, b_mem_offset, b_mem_data, b_rdata;
  logic        b_f_ack, b_x_ack, b_busy;

  int n_chk;
  int n_fail;
  int ack_cnt;

  mem_port_arbiter #(.MEM_LAT(1)) dut_a (
    .clk(clk), .init_n(init_n),
    .f_req(f_req), .f_address(f_address), .f_offset(f_offset),
    .x_req(x_req), .x_mode(x_mode), .x_address(x_address),
    .x_offset(x_offset), .x_data(x_data),
    .mem_mode(a_mem_mode), .mem_address(a_mem_address),
    .mem_offset(a_mem_offset), .mem_data(a_mem_data),
    .mem_data_out(mem_data_out),
    .f_ack(a_f_ack), .x_ack(a_x_ack), .rdata(a_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.MEM_LAT(3)) dut_b (
    .clk(clk), .init_n(init_n),
    .f_req(f_req), .f_address(f_address), .f_offset(f_offset),
    .x_req(x_req), .x_mode(x_mode), .x_address(x_address),
    .x_offset(x_offset), .x_data(x_data),
    .mem_mode(b_mem_mode), .mem_address(b_mem_address),
    .mem_offset(b_mem_offset), .mem_data(b_mem_data),
    .mem_data_out(mem_data_out),
    .f_ack(b_f_ack), .x_ack(b_x_ack), .rdata(b_rdata), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    init_n = 1'b0;
    f_req = 1'b0; f_address = 32'h0; f_offset = 32'h0;
    x_req = 1'b0; x_mode = 2'b00; x_address = 32'h0; x_offset = 32'h0; x_data = 32'h0;
    mem_data_out = 32'h0;

    // Reset state
    tick(); tick();
    check("rst_mem_mode", 32'(a_mem_mode), 32'h0);
    check("rst_busy", 32'(a_busy), 32'h0);
    check("rst_f_ack", 32'(a_f_ack), 32'h0);
    check("rst_x_ack", 32'(a_x_ack), 32'h0);
    check("rst_rdata", a_rdata, 32'h0);
    check("rst_mem_address", a_mem_address, 32'h0);

    // Fetch only: grant on first edge after release, ack 3 cycles later
    init_n = 1'b1;
    f_req = 1'b1; f_address = 32'h0; f_offset = 32'd5;
    mem_data_out = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("fetch_mode_%0d", i), 32'(a_mem_mode), 32'h0);
      check($sformatf("fetch_f_ack_%0d", i), 32'(a_f_ack), (i == 3) ? 32'h1 : 32'h0);
      check($sformatf("fetch_x_ack_%0d", i), 32'(a_x_ack), 32'h0);
      check($sformatf("fetch_busy_%0d", i), 32'(a_busy), (i <= 2) ? 32'h1 : 32'h0);
      if (i == 0) check("fetch_offset", a_mem_offset, 32'd5);
      if (i == 3) begin
        check("fetch_rdata", a_rdata, 32'hDEADBEEF);
        f_req = 1'b0;
      end
    end

    // Simultaneous requests after reset: fetch, execute, fetch, execute
    init_n = 1'b0;
    tick();
    init_n = 1'b1;
    f_req = 1'b1; f_address = 32'd1;
    x_req = 1'b1; x_mode = 2'b00; x_address = 32'd2;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("rr_f_ack_%0d", i), 32'(a_f_ack), (i == 3 || i == 11) ? 32'h1 : 32'h0);
      check($sformatf("rr_x_ack_%0d", i), 32'(a_x_ack), (i == 7 || i == 15) ? 32'h1 : 32'h0);
      if (i % 4 == 0)
        check($sformatf("rr_addr_%0d", i), a_mem_address, (i % 8 == 0) ? 32'd1 : 32'd2);
    end
    f_req = 1'b0;
    x_req = 1'b0;
    tick(); tick();

    // Execute write
    x_req = 1'b1; x_mode = 2'b01; x_address = 32'd2; x_offset = 32'd7; x_data = 32'h12345678;
    mem_data_out = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("wr_mode_%0d", i), 32'(a_mem_mode), (i == 0) ? 32'h1 : 32'h0);
      check($sformatf("wr_x_ack_%0d", i), 32'(a_x_ack), (i == 3) ? 32'h1 : 32'h0);
      check($sformatf("wr_f_ack_%0d", i), 32'(a_f_ack), 32'h0);
      if (i == 0) begin
        check("wr_addr", a_mem_address, 32'd2);
        check("wr_offset", a_mem_offset, 32'd7);
        check("wr_data", a_mem_data, 32'h12345678);
      end
      if (i == 3) begin
        check("wr_rdata", a_rdata, 32'h0BADF00D);
        x_req = 1'b0;
      end
    end

    // Reset during WAIT: everything clears at once, no ack, restart after release
    f_req = 1'b1; f_offset = 32'd9;
    tick(); tick();
    check("rw_busy_before", 32'(a_busy), 32'h1);
    init_n = 1'b0;
    #1;
    check("rw_busy", 32'(a_busy), 32'h0);
    check("rw_offset", a_mem_offset, 32'h0);
    check("rw_rdata", a_rdata, 32'h0);
    check("rw_mode", 32'(a_mem_mode), 32'h0);
    tick(); tick();
    check("rw_f_ack_held", 32'(a_f_ack), 32'h0);
    init_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rw_f_ack_%0d", i), 32'(a_f_ack), (i == 3) ? 32'h1 : 32'h0);
      if (i == 0) begin
        check("rw_restart_busy", 32'(a_busy), 32'h1);
        check("rw_restart_offset", a_mem_offset, 32'd9);
      end
    end
    f_req = 1'b0;
    tick();

    // Request withdrawn in ISSUE, fields altered: command unchanged, single ack
    x_req = 1'b1; x_mode = 2'b00; x_address = 32'd5; x_offset = 32'd3;
    mem_data_out = 32'hA5A50001;
    ack_cnt = 0;
    tick();
    x_req = 1'b0; x_offset = 32'd99;
    check("wd_offset_issue", a_mem_offset, 32'd3);
    for (int i = 1; i < 8; i++) begin
      tick();
      if (a_x_ack) ack_cnt++;
      if (i == 1) check("wd_offset_wait", a_mem_offset, 32'd3);
      if (i == 3) begin
        check("wd_x_ack", 32'(a_x_ack), 32'h1);
        check("wd_rdata", a_rdata, 32'hA5A50001);
      end
    end
    check("wd_ack_count", 32'(ack_cnt), 32'd1);

    // Alloc on the MEM_LAT=3 instance
    init_n = 1'b0;
    tick();
    init_n = 1'b1;
    x_req = 1'b1; x_mode = 2'b10; x_address = 32'd0; x_offset = 32'd16; x_data = 32'h0;
    mem_data_out = 32'd4;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("al_mode_%0d", i), 32'(b_mem_mode), (i == 0) ? 32'h2 : 32'h0);
      check($sformatf("al_busy_%0d", i), 32'(b_busy), (i <= 4) ? 32'h1 : 32'h0);
      check($sformatf("al_x_ack_%0d", i), 32'(b_x_ack), (i == 5) ? 32'h1 : 32'h0);
      if (i == 0) check("al_offset", b_mem_offset, 32'd16);
      if (i == 5) begin
        check("al_rdata", b_rdata, 32'd4);
        x_req = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
